// File: rtl/vga_scan_if.sv
// ---- vga_scan_if : pixel-rate enable, renderer colour/address and VGA pin bundle (rev 1.0) ----
`default_nettype none

interface vga_scan_if;
  logic        pix_en;
  logic [11:0] d_in;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic        active;
  logic [3:0]  r;
  logic [3:0]  g;
  logic [3:0]  b;
  logic        hs;
  logic        vs;
  logic        frame_start;

  modport master (
    input  pix_en, d_in,
    output row_addr, col_addr, active, r, g, b, hs, vs, frame_start
  );

  modport slave (
    output pix_en, d_in,
    input  row_addr, col_addr, active, r, g, b, hs, vs, frame_start
  );
endinterface

`default_nettype wire

// File: rtl/vga_scan_timing.sv
// ---- vga_scan_timing : VGA scan counters, sync generation and registered colour stage (rev 1.0) ----
`default_nettype none

module vga_scan_timing #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       clk,
  input  logic       rst,
  vga_scan_if.master bus
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_params
      $error("vga_scan_timing: line or frame total exceeds 10-bit counter range");
    end
  endgenerate

  // 11-bit bounds so a sync end equal to 1024 still compares correctly
  localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);

  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [10:0] h_ext;
  logic [10:0] v_ext;
  logic        visible;
  logic        hs_raw;
  logic        vs_raw;
  logic        at_frame_end;

  assign h_ext        = {1'b0, h_cnt};
  assign v_ext        = {1'b0, v_cnt};
  assign visible      = (h_ext < H_VIS_END) && (v_ext < V_VIS_END);
  assign hs_raw       = !((h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END));
  assign vs_raw       = !((v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END));
  assign at_frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);

  assign bus.row_addr = visible ? v_cnt[8:0] : 9'd0;
  assign bus.col_addr = visible ? h_cnt : 10'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= 10'd0;
      v_cnt <= 10'd0;
    end else if (bus.pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= 10'd0;
        v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Not gated by pix_en: the pulse must drop after one clk even if the next tick is far away
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.frame_start <= 1'b0;
    end else begin
      bus.frame_start <= bus.pix_en && at_frame_end;
    end
  end

  // Colour and syncs share one register stage so they stay aligned at the pins
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.r      <= 4'h0;
      bus.g      <= 4'h0;
      bus.b      <= 4'h0;
      bus.hs     <= 1'b1;
      bus.vs     <= 1'b1;
      bus.active <= 1'b0;
    end else if (bus.pix_en) begin
      bus.r      <= visible ? bus.d_in[11:8] : 4'h0;
      bus.g      <= visible ? bus.d_in[7:4]  : 4'h0;
      bus.b      <= visible ? bus.d_in[3:0]  : 4'h0;
      bus.hs     <= hs_raw;
      bus.vs     <= vs_raw;
      bus.active <= visible;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_scan_timing.sv
// ---- tb_vga_scan_timing : scoreboard bench for vga_scan_timing on a shrunken raster (rev 1.0) ----
`default_nettype none

module tb_vga_scan_timing;
  // Small raster keeps several whole frames inside a short run
  localparam int HV = 16, HF = 4, HS = 6, HB = 6;
  localparam int VV = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;

  typedef struct packed {
    logic [11:0] rgb;
    logic        act;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [8:0]  row;
    logic [9:0]  col;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   mode = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t q[$];
  exp_t e;

  // Model state
  int          mh = 0, mv = 0;
  logic [11:0] p_rgb = 12'h0;
  logic        p_act = 1'b0, p_hs = 1'b1, p_vs = 1'b1, p_fs = 1'b0;

  // hs pulse-width watcher for the 1-in-4 enable phase
  logic gate_phase = 1'b0;
  int   hs_run = 0;
  logic run_gated = 1'b0;
  int   hs_width_checks = 0;

  vga_scan_if bus ();

  vga_scan_timing #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Renderer stand-in: colour derived from the address the DUT presents
  always_comb begin
    bus.d_in = 12'hABC;
    case (mode)
      1:       bus.d_in = {2'b00, bus.col_addr};
      2:       bus.d_in = {bus.row_addr[5:0], bus.col_addr[5:0]};
      default: bus.d_in = 12'hABC;
    endcase
  end

  function automatic logic [11:0] colour(input int m, input int h, input int v);
    logic [31:0] hh, vv;
    hh = h;
    vv = v;
    case (m)
      1:       return hh[11:0];
      2:       return {vv[5:0], hh[5:0]};
      default: return 12'hABC;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
  endtask

  // One clk cycle of stimulus; the expected post-edge state is queued for the monitor
  task automatic step(input logic rs, input logic en);
    logic vis;
    exp_t x;
    rst = rs;
    bus.pix_en = en;
    @(posedge clk);
    #1;
    if (rs) begin
      mh = 0; mv = 0;
      p_rgb = 12'h0; p_act = 1'b0; p_hs = 1'b1; p_vs = 1'b1; p_fs = 1'b0;
    end else if (en) begin
      vis   = (mh < HV) && (mv < VV);
      p_rgb = vis ? colour(mode, mh, mv) : 12'h0;
      p_act = vis;
      p_hs  = !((mh >= HV + HF) && (mh < HV + HF + HS));
      p_vs  = !((mv >= VV + VF) && (mv < VV + VF + VS));
      p_fs  = (mh == HT - 1) && (mv == VT - 1);
      mh = mh + 1;
      if (mh == HT) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end
    end else begin
      p_fs = 1'b0;
    end
    vis   = (mh < HV) && (mv < VV);
    x.rgb = p_rgb;
    x.act = p_act;
    x.hs  = p_hs;
    x.vs  = p_vs;
    x.fs  = p_fs;
    x.row = vis ? 9'(mv) : 9'd0;
    x.col = vis ? 10'(mh) : 10'd0;
    q.push_back(x);
  endtask

  // Monitor: pops one expectation per sampled cycle, away from the active edge
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      check("pins", {44'd0, bus.r, bus.g, bus.b, bus.active, bus.hs, bus.vs},
                    {44'd0, e.rgb, e.act, e.hs, e.vs});
      check("frame_start", {63'd0, bus.frame_start}, {63'd0, e.fs});
      check("addr", {45'd0, bus.row_addr, bus.col_addr}, {45'd0, e.row, e.col});
    end
  end

  always @(negedge clk) begin
    if (bus.hs === 1'b0) begin
      if (hs_run == 0) run_gated = gate_phase;
      hs_run = hs_run + 1;
    end else begin
      if (hs_run > 0 && run_gated && gate_phase) begin
        check("hs_low_width_gated", 64'(hs_run), 64'(4 * HS));
        hs_width_checks++;
      end
      hs_run = 0;
    end
  end

  initial begin
    rst = 1'b1;
    bus.pix_en = 1'b1;
    mode = 0;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);

    // Constant colour through a full frame wrap, then address-echo colour
    for (int i = 0; i < HT * VT + 40; i++) step(1'b0, 1'b1);
    mode = 1;
    for (int i = 0; i < HT * VT; i++) step(1'b0, 1'b1);

    // Reset in the middle of a visible line
    while (mh != 10) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 3 * HT; i++) step(1'b0, 1'b1);

    // One enabled cycle in four across two frame wraps
    mode = 2;
    gate_phase = 1'b1;
    for (int i = 0; i < 4 * (2 * HT * VT + HT); i++) step(1'b0, (i % 4) == 0);
    gate_phase = 1'b0;

    // Irregular enable pattern
    for (int i = 0; i < 400; i++) step(1'b0, 1'($urandom_range(0, 1)));

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", 64'(q.size()), 64'd0);
    check("hs_width_seen", 64'(hs_width_checks > 0), 64'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
